// File: rtl/surfturf_cmd_arbiter_if.sv
// Command-arbiter stream bundle: run-command, trigger and firmware-byte
// request streams plus the registered slot command outputs.
// Payload widths come from the rack bus macros, which default to 2 and 15 bits.
`ifndef RACKBUS_RUNCMD_BITS
`define RACKBUS_RUNCMD_BITS 2
`endif
`ifndef RACKBUS_TRIG_BITS
`define RACKBUS_TRIG_BITS 15
`endif

interface surfturf_cmd_arbiter_if;
  logic [`RACKBUS_RUNCMD_BITS-1:0] runcmd_tdata;
  logic                            runcmd_tvalid;
  logic                            runcmd_tready;
  logic [`RACKBUS_TRIG_BITS-1:0]   trig_tdata;
  logic                            trig_tvalid;
  logic                            trig_tready;
  logic [7:0]                      fw_tdata;
  logic                            fw_tvalid;
  logic                            fw_tready;
  logic [1:0]                      fw_mark_i;
  logic                            fw_marked_o;
  logic [23:0]                     cmd_o;
  logic                            cmd_valid_o;

  modport master (
    output runcmd_tdata, runcmd_tvalid, input runcmd_tready,
    output trig_tdata, trig_tvalid, input trig_tready,
    output fw_tdata, fw_tvalid, input fw_tready,
    output fw_mark_i, input fw_marked_o,
    input cmd_o, cmd_valid_o
  );

  modport slave (
    input runcmd_tdata, runcmd_tvalid, output runcmd_tready,
    input trig_tdata, trig_tvalid, output trig_tready,
    input fw_tdata, fw_tvalid, output fw_tready,
    input fw_mark_i, output fw_marked_o,
    output cmd_o, cmd_valid_o
  );
endinterface

// File: rtl/surfturf_cmd_arbiter.sv
// Slot-based command arbiter: on each slot strobe picks one of runcmd / trig /
// fw (runcmd > trig > fw, fw promoted over trig after FW_MAX_WAIT lost slots),
// accepts that beat combinationally and issues a 24-bit command word one
// cycle later. Optional statistics counters are built when the macro
// SURFTURF_ARB_STATS_EN is defined; otherwise the stat outputs are tied to 0.
module surfturf_cmd_arbiter #(
  parameter int FW_MAX_WAIT  = 4,
  parameter     SYS_CLK_TYPE = "NONE"
) (
  input  logic                  sysclk_i,
  input  logic                  sysclk_rst_i,
  input  logic                  enable_i,
  input  logic                  slot_i,
  surfturf_cmd_arbiter_if.slave bus,
  input  logic                  stat_clr_i,
  output logic [15:0]           stat_trig_o,
  output logic [15:0]           stat_fw_o,
  output logic [15:0]           stat_starve_o
);

  localparam int WAIT_W = $clog2(FW_MAX_WAIT + 1);

  // The clock-type tag only steers timing attributes; no logic depends on it.
  if (SYS_CLK_TYPE == "") begin : g_untagged_clk
  end

  typedef enum logic {ST_DISABLED, ST_ACTIVE} state_e;
  typedef enum logic [1:0] {
    SRC_IDLE = 2'b00,
    SRC_RUN  = 2'b01,
    SRC_TRIG = 2'b10,
    SRC_FW   = 2'b11
  } src_e;

  state_e              state_q, state_d;
  logic   [WAIT_W-1:0] wait_q, wait_d;
  logic                arb_p0;
  src_e                win_p0;
  logic                starve_p0;
  logic   [14:0]       payload_p0;
  logic   [1:0]        mark_p0;
  logic   [23:0]       cmd_p1;
  logic                vld_p1;
  logic                marked_p1;
  logic                fw_overdue;

  // Command word: type, fw mark, five zero bits, zero-extended payload.
  function automatic logic [23:0] pack_cmd(input src_e src, input logic [1:0] mark,
                                           input logic [14:0] payload);
    return {src, mark, 5'b0, payload};
  endfunction

  assign fw_overdue = (wait_q == WAIT_W'(FW_MAX_WAIT));

  // Next-state, winner selection and ready generation for the slot cycle.
  always_comb begin
    state_d           = state_q;
    arb_p0            = 1'b0;
    win_p0            = SRC_IDLE;
    starve_p0         = 1'b0;
    payload_p0        = '0;
    mark_p0           = '0;
    wait_d            = wait_q;
    bus.runcmd_tready = 1'b0;
    bus.trig_tready   = 1'b0;
    bus.fw_tready     = 1'b0;
    if (!sysclk_rst_i && slot_i) begin
      case (state_q)
        ST_DISABLED: if (enable_i)  state_d = ST_ACTIVE;
        ST_ACTIVE:   if (!enable_i) state_d = ST_DISABLED;
        default:     state_d = ST_DISABLED;
      endcase
      arb_p0 = (state_d == ST_ACTIVE);
    end
    if (arb_p0) begin
      if (bus.runcmd_tvalid) begin
        win_p0            = SRC_RUN;
        payload_p0        = 15'(bus.runcmd_tdata);
        bus.runcmd_tready = 1'b1;
      end else if (bus.trig_tvalid && !(bus.fw_tvalid && fw_overdue)) begin
        win_p0          = SRC_TRIG;
        payload_p0      = 15'(bus.trig_tdata);
        bus.trig_tready = 1'b1;
      end else if (bus.fw_tvalid) begin
        win_p0        = SRC_FW;
        starve_p0     = bus.trig_tvalid;
        payload_p0    = 15'(bus.fw_tdata);
        mark_p0       = bus.fw_mark_i;
        bus.fw_tready = 1'b1;
      end
      if (bus.fw_tvalid && (win_p0 != SRC_FW)) begin
        if (!fw_overdue) wait_d = wait_q + WAIT_W'(1);
      end else begin
        wait_d = '0;
      end
    end
  end

  // State, wait counter and the registered slot command (p0 -> p1).
  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      state_q   <= ST_DISABLED;
      wait_q    <= '0;
      cmd_p1    <= '0;
      vld_p1    <= 1'b0;
      marked_p1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      vld_p1    <= slot_i;
      marked_p1 <= arb_p0 && (win_p0 == SRC_FW) && (bus.fw_mark_i != 2'b00);
      if (slot_i) cmd_p1 <= arb_p0 ? pack_cmd(win_p0, mark_p0, payload_p0) : '0;
    end
  end

  assign bus.cmd_o       = cmd_p1;
  assign bus.cmd_valid_o = vld_p1;
  assign bus.fw_marked_o = marked_p1;

`ifdef SURFTURF_ARB_STATS_EN
  logic [15:0] st_trig_q, st_fw_q, st_starve_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Statistics counters; a clear overrides any increment in the same cycle.
  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i || stat_clr_i) begin
      st_trig_q   <= '0;
      st_fw_q     <= '0;
      st_starve_q <= '0;
    end else begin
      if (arb_p0 && (win_p0 == SRC_TRIG)) st_trig_q   <= sat_inc(st_trig_q);
      if (arb_p0 && (win_p0 == SRC_FW))   st_fw_q     <= sat_inc(st_fw_q);
      if (arb_p0 && starve_p0)            st_starve_q <= sat_inc(st_starve_q);
    end
  end

  assign stat_trig_o   = st_trig_q;
  assign stat_fw_o     = st_fw_q;
  assign stat_starve_o = st_starve_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_trig_o     = '0;
  assign stat_fw_o       = '0;
  assign stat_starve_o   = '0;
`endif

endmodule

// File: tb/tb_surfturf_cmd_arbiter.sv
// Bench for surfturf_cmd_arbiter: slot-level model checked every cycle plus
// directed slots with literal expectations. Honours SURFTURF_ARB_STATS_EN.
`ifndef RACKBUS_RUNCMD_BITS
`define RACKBUS_RUNCMD_BITS 2
`endif
`ifndef RACKBUS_TRIG_BITS
`define RACKBUS_TRIG_BITS 15
`endif

module tb_surfturf_cmd_arbiter;
  localparam int FW_MAX = 4;
`ifdef SURFTURF_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, slot, stat_clr;
  logic [15:0] stat_trig, stat_fw, stat_starve;
  int n_checks = 0;
  int n_fail = 0;

  surfturf_cmd_arbiter_if bus();

  surfturf_cmd_arbiter #(.FW_MAX_WAIT(FW_MAX), .SYS_CLK_TYPE("NONE")) dut (
    .sysclk_i(clk), .sysclk_rst_i(rst), .enable_i(en), .slot_i(slot),
    .bus(bus), .stat_clr_i(stat_clr),
    .stat_trig_o(stat_trig), .stat_fw_o(stat_fw), .stat_starve_o(stat_starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model, compared every cycle ----------------
  int          m_wait = 0;
  logic [23:0] m_cmd = '0;
  logic        m_vld = 1'b0, m_mk = 1'b0;
  int          m_st_t = 0, m_st_f = 0, m_st_s = 0;

  always @(negedge clk) begin
    int w;
    bit starve, arb;
    chk("cmd_o", 32'(bus.cmd_o), 32'(m_cmd));
    chk("cmd_valid_o", 32'(bus.cmd_valid_o), 32'(m_vld));
    chk("fw_marked_o", 32'(bus.fw_marked_o), 32'(m_mk));
    chk("stat_trig_o", 32'(stat_trig), 32'(m_st_t));
    chk("stat_fw_o", 32'(stat_fw), 32'(m_st_f));
    chk("stat_starve_o", 32'(stat_starve), 32'(m_st_s));
    // winner: 0 idle, 1 runcmd, 2 trig, 3 fw
    arb = !rst && slot && en;
    w = 0;
    starve = 0;
    if (arb) begin
      if (bus.runcmd_tvalid) w = 1;
      else if (bus.fw_tvalid && (!bus.trig_tvalid || m_wait == FW_MAX)) begin
        w = 3;
        starve = bus.trig_tvalid;
      end else if (bus.trig_tvalid) w = 2;
    end
    chk("treadys", 32'({bus.runcmd_tready, bus.trig_tready, bus.fw_tready}),
        32'({w == 1, w == 2, w == 3}));
    if (rst) begin
      m_wait = 0; m_cmd = '0; m_vld = 0; m_mk = 0;
      m_st_t = 0; m_st_f = 0; m_st_s = 0;
    end else begin
      m_vld = slot;
      m_mk  = (w == 3) && (bus.fw_mark_i != 2'b00);
      if (slot) begin
        case (w)
          1:       m_cmd = 24'h400000 + 24'(bus.runcmd_tdata);
          2:       m_cmd = 24'h800000 + 24'(bus.trig_tdata);
          3:       m_cmd = 24'hC00000 + (24'(bus.fw_mark_i) << 20) + 24'(bus.fw_tdata);
          default: m_cmd = '0;
        endcase
      end
      if (arb) begin
        if (bus.fw_tvalid && w != 3) m_wait = (m_wait < FW_MAX) ? m_wait + 1 : FW_MAX;
        else m_wait = 0;
      end
      if (STATS) begin
        if (stat_clr) begin
          m_st_t = 0; m_st_f = 0; m_st_s = 0;
        end else begin
          if (w == 2 && m_st_t < 65535) m_st_t++;
          if (w == 3 && m_st_f < 65535) m_st_f++;
          if (starve && m_st_s < 65535) m_st_s++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_slot(output logic [2:0] rdy);
    slot = 1'b1;
    #2;
    rdy = {bus.runcmd_tready, bus.trig_tready, bus.fw_tready};
    @(posedge clk); #1;
    slot = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] rdy;
    rst = 1; en = 0; slot = 0; stat_clr = 0;
    bus.runcmd_tdata = '0; bus.runcmd_tvalid = 0;
    bus.trig_tdata = '0; bus.trig_tvalid = 0;
    bus.fw_tdata = '0; bus.fw_tvalid = 0; bus.fw_mark_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd", 32'(bus.cmd_o), 32'h0);
    chk("rst_vld", 32'(bus.cmd_valid_o), 32'h0);
    chk("rst_marked", 32'(bus.fw_marked_o), 32'h0);
    rst = 0;
    idle(1);

    // runcmd beats trig
    en = 1;
    bus.runcmd_tdata = 2'b11; bus.runcmd_tvalid = 1;
    bus.trig_tdata = 15'h1234; bus.trig_tvalid = 1;
    do_slot(rdy);
    chk("run_rdy", 32'(rdy), 32'b100);
    chk("run_cmd", 32'(bus.cmd_o), 32'h400003);
    chk("run_vld", 32'(bus.cmd_valid_o), 32'h1);
    idle(1);
    chk("run_hold", 32'(bus.cmd_o), 32'h400003);
    chk("run_vld_drop", 32'(bus.cmd_valid_o), 32'h0);

    // trig and fw continuously valid: four trig slots, then fw by starvation
    bus.runcmd_tvalid = 0;
    bus.fw_tdata = 8'h3C; bus.fw_tvalid = 1;
    for (int i = 1; i <= 4; i++) begin
      do_slot(rdy);
      chk("starve_trig_rdy", 32'(rdy), 32'b010);
      chk("starve_trig_cmd", 32'(bus.cmd_o), 32'h801234);
      idle(2);
    end
    do_slot(rdy);
    chk("starve_fw_rdy", 32'(rdy), 32'b001);
    chk("starve_fw_cmd", 32'(bus.cmd_o), 32'hC0003C);
    if (STATS) begin
      chk("starve_stat_s", 32'(stat_starve), 32'd1);
      chk("starve_stat_t", 32'(stat_trig), 32'd4);
    end
    idle(1);
    do_slot(rdy);
    chk("restart_trig_cmd", 32'(bus.cmd_o), 32'h801234);
    idle(1);

    // lone marked fw beat
    bus.trig_tvalid = 0;
    bus.fw_tdata = 8'hA5; bus.fw_mark_i = 2'b10;
    do_slot(rdy);
    chk("mark_rdy", 32'(rdy), 32'b001);
    chk("mark_cmd", 32'(bus.cmd_o), 32'hE000A5);
    chk("mark_pulse", 32'(bus.fw_marked_o), 32'h1);
    idle(1);
    chk("mark_pulse_end", 32'(bus.fw_marked_o), 32'h0);
    bus.fw_mark_i = 2'b00;

    // trig valid only between slots, nothing valid at the slot -> idle word
    bus.fw_tvalid = 0; bus.trig_tvalid = 1;
    idle(1);
    bus.trig_tvalid = 0;
    do_slot(rdy);
    chk("empty_rdy", 32'(rdy), 32'b000);
    chk("empty_cmd", 32'(bus.cmd_o), 32'h0);
    chk("empty_vld", 32'(bus.cmd_valid_o), 32'h1);
    idle(1);

    // disabled: every slot idles, no ready
    en = 0;
    bus.runcmd_tvalid = 1; bus.trig_tvalid = 1; bus.fw_tvalid = 1;
    for (int i = 0; i < 3; i++) begin
      do_slot(rdy);
      chk("dis_rdy", 32'(rdy), 32'b000);
      chk("dis_cmd", 32'(bus.cmd_o), 32'h0);
      chk("dis_vld", 32'(bus.cmd_valid_o), 32'h1);
      idle(1);
    end

    // reset coincident with a slot
    en = 1; bus.runcmd_tvalid = 0; bus.fw_tvalid = 0;
    do_slot(rdy);
    chk("pre_rst_cmd", 32'(bus.cmd_o), 32'h801234);
    idle(1);
    rst = 1;
    do_slot(rdy);
    chk("rst_slot_rdy", 32'(rdy), 32'b000);
    chk("rst_slot_cmd", 32'(bus.cmd_o), 32'h0);
    chk("rst_slot_vld", 32'(bus.cmd_valid_o), 32'h0);
    rst = 0;
    idle(1);

    // statistics clear against a simultaneous trig issue
    do_slot(rdy);
    if (STATS) chk("stat_one", 32'(stat_trig), 32'd1);
    idle(1);
    stat_clr = 1;
    do_slot(rdy);
    stat_clr = 0;
    chk("clr_trig_cmd", 32'(bus.cmd_o), 32'h801234);
    chk("clr_stat_trig", 32'(stat_trig), 32'd0);
    bus.trig_tvalid = 0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
